counter_ctrl: RTL
=================

// Module: counter_ctrl
// PURPOSE
//   Sequencer for the async-reset/sync-clear counter datapath. Drives the counter's
//   sync clear and count enable, watches its count value against a programmed limit,
//   and runs one-shot or periodic count sequences with pause/resume/abort.
//   Sits between software-style start/stop controls and a WIDTH-bit counter instance.
// PARAMETERS
//   WIDTH     8  counter / limit width in bits
//   PRESCALE  4  enable divide ratio (>=1); used only with COUNTER_CTRL_PRESCALE_EN
// PORTS
//   C         in   1      clock, rising edge
//   CLR       in   1      asynchronous reset, active-high
//   START     in   1      start (from IDLE) / resume (from HOLD), level sampled each edge
//   STOP      in   1      pause (RUN) / abort (HOLD)
//   PERIODIC  in   1      mode select, latched on start: 1 = auto-restart at limit
//   LIMIT     in   WIDTH  terminal count, latched on start
//   CNT_VAL   in   WIDTH  current value from the counter
//   CNT_CLR   out  1      synchronous clear to the counter
//   CNT_EN    out  1      count enable to the counter (+1 per enabled edge)
//   BUSY      out  1      high in any state except IDLE
//   DONE      out  1      one-cycle pulse per terminal-count event
//   WRAPS     out  8      periodic terminal events since last start, saturates at 255
// BEHAVIOUR
//   - CLR high: state IDLE; CNT_CLR, CNT_EN, BUSY, DONE = 0; WRAPS = 0; lim_q = 0;
//     mode_q = 0. Takes effect immediately, including mid-sequence; no DONE is generated.
//   - States: IDLE, CLEAR, RUN, HOLD, FINISH. CNT_CLR = (state==CLEAR).
//     CNT_EN = (state==RUN) && (CNT_VAL != lim_q) (Mealy).
//   - IDLE: START=1 -> CLEAR; latch lim_q<=LIMIT and mode_q<=PERIODIC; WRAPS<=0.
//   - CLEAR: one cycle, then RUN unconditionally. STOP is ignored in CLEAR.
//   - RUN: STOP=1 -> HOLD (STOP has priority over START and over terminal detect).
//     Terminal (CNT_VAL==lim_q): one-shot -> FINISH; periodic -> CLEAR and WRAPS+1.
//   - HOLD: CNT_EN=0, counter holds. STOP=1 -> IDLE (abort, no DONE). START=1 -> RUN
//     (resume, no clear). STOP has priority. Otherwise stay.
//   - FINISH: one cycle, then IDLE. START is ignored in FINISH.
//   - DONE: registered. High exactly one cycle, in the cycle after terminal detect,
//     i.e. while in FINISH (one-shot) or the following CLEAR (periodic).
//   - Timing: START sampled at edge k -> CLEAR in cycle k+1, RUN from k+2.
//     One-shot: LIMIT enable cycles, then one terminal cycle, then FINISH.
//     Periodic period = LIMIT+2 cycles.
//   - LIMIT=0: the first RUN cycle is terminal, with CNT_EN never asserted.
//   - CNT_VAL > lim_q (external disturbance): no terminal; the counter keeps counting
//     and wraps to lim_q (modulo 2^WIDTH). LIMIT and PERIODIC changes during a run are
//     ignored.
// CONFIGURATION
//   COUNTER_CTRL_PRESCALE_EN defined:
//     - An internal prescale counter p (0..PRESCALE-1) is zeroed in CLEAR, advances each
//       RUN cycle, and holds in HOLD.
//     - CNT_EN = (state==RUN) && (CNT_VAL != lim_q) && (p==PRESCALE-1).
//     - Terminal detect is unchanged.
//   COUNTER_CTRL_PRESCALE_EN undefined: no prescale logic; CNT_EN as in BEHAVIOUR, and
//     PRESCALE has no effect.
// TESTING (bench instantiates counter_ctrl + WIDTH-bit counter, CNT_CLR->DCLR-style clear)
//   1. One-shot LIMIT=5, START 1 cycle -> CNT_CLR 1 cycle; CNT_EN 5 consecutive cycles;
//      CNT_VAL ends 5; DONE 1 pulse; BUSY low 8 cycles after START edge; WRAPS=0.
//   2. Periodic LIMIT=3, run 3 periods -> DONE pulses exactly 5 cycles apart;
//      CNT_VAL sequence 0,1,2,3,0,...; WRAPS=3; STOP then STOP -> IDLE, BUSY=0.
//   3. One-shot LIMIT=6, STOP after CNT_VAL=2, hold 4 cycles, START -> CNT_VAL stays 2
//      during HOLD, resumes 3..6; total CNT_EN cycles = 6; one DONE.
//   4. STOP and START together in RUN -> HOLD; then STOP in HOLD -> IDLE, no DONE;
//      LIMIT=0 one-shot -> CNT_EN never high, DONE 3 cycles after START edge.
//   5. CLR pulse (2 ns, between clock edges) mid-RUN at CNT_VAL=4 -> all outputs 0
//      before next edge; WRAPS=0; next START restarts from clear.
//   6. With COUNTER_CTRL_PRESCALE_EN, PRESCALE=4, LIMIT=2 -> CNT_EN pulses on RUN
//      cycles 4 and 8 only; DONE after CNT_VAL=2.

Source files
------------

// File: rtl/counter_ctrl.sv
// Sequencer for a WIDTH-bit counter: one-shot/periodic runs to a latched limit with pause/resume/abort.
// Optional enable prescaler is built when COUNTER_CTRL_PRESCALE_EN is defined.
module counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             START,
  input  logic             STOP,
  input  logic             PERIODIC,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic [WIDTH-1:0] CNT_VAL,
  output logic             CNT_CLR,
  output logic             CNT_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       WRAPS
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_HOLD,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;
  logic [7:0]       wraps_q, wraps_d;
  logic             done_q, done_d;
  logic             terminal;
  logic             en_tick;

  assign terminal = (CNT_VAL == lim_q);

`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam int PRESCALE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESCALE_W-1:0] P_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] p_q, p_d;

  // Phase restarts with every clear so each period sees the same enable pattern.
  always_comb begin
    p_d = p_q;
    if (state_q == S_CLEAR) begin
      p_d = '0;
    end else if (state_q == S_RUN) begin
      p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign en_tick = (p_q == P_LAST);
`else
  localparam int prescale_unused = PRESCALE;
  assign en_tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    wraps_d = wraps_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CLEAR;
          lim_d   = LIMIT;
          mode_d  = PERIODIC;
          wraps_d = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // A pause request wins over a terminal count in the same cycle.
        if (STOP) begin
          state_d = S_HOLD;
        end else if (terminal) begin
          done_d = 1'b1;
          if (mode_q) begin
            state_d = S_CLEAR;
            if (wraps_q != 8'hFF) begin
              wraps_d = wraps_q + 8'd1;
            end
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_HOLD: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (START) begin
          state_d = S_RUN;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      lim_q   <= '0;
      mode_q  <= 1'b0;
      wraps_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      wraps_q <= wraps_d;
      done_q  <= done_d;
    end
  end

  assign CNT_CLR = (state_q == S_CLEAR);
  assign CNT_EN  = (state_q == S_RUN) && (CNT_VAL != lim_q) && en_tick;
  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = done_q;
  assign WRAPS   = wraps_q;

endmodule
